alu_control_mc: RTL and testbench

- Multicycle successor to the single-cycle ALU control decoder in the MIPS core.
- Decodes aluop/funct into an ALU control code, with control width and datapath width parametrised.
- Adds an iterative unsigned multiply/divide sequencer with HI/LO registers, MFHI/MFLO readout and a stall output.
- Sits between the main control FSM and the datapath ALU.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/alu_control_mc_if.sv | 29 ++
 rtl/muldiv_iter.sv | 74 +++++++
 rtl/alu_control_mc.sv | 169 ++++++++++++++++
 tb/tb_alu_control_mc.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multicycle ALU control block: aluop/funct values,
// ALU operation codes and the sequencer state type.
package alu_ctrl_pkg;

  localparam int unsigned CODE_W = 3;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_RSVD  = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;

  localparam logic [CODE_W-1:0] ALU_ADD = 3'b010;
  localparam logic [CODE_W-1:0] ALU_SUB = 3'b110;
  localparam logic [CODE_W-1:0] ALU_AND = 3'b000;
  localparam logic [CODE_W-1:0] ALU_OR  = 3'b001;
  localparam logic [CODE_W-1:0] ALU_SLT = 3'b111;

  // SFIX is only reachable when signed mul/div decoding is built in.
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIN, SFIX} state_t;

endpackage

// File: rtl/alu_control_mc_if.sv
// Bus between the main control/datapath and the multicycle ALU control block.
interface alu_control_mc_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 3
);
  logic [5:0]        funct;
  logic [1:0]        aluop;
  logic              valid_in;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [CTRL_W-1:0] alucontrol;
  logic              illegal;
  logic              busy;
  logic              stall;
  logic              done;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  mf_data;

  modport master (
    output funct, aluop, valid_in, a, b,
    input  alucontrol, illegal, busy, stall, done, hi, lo, mf_data
  );

  modport slave (
    input  funct, aluop, valid_in, a, b,
    output alucontrol, illegal, busy, stall, done, hi, lo, mf_data
  );
endinterface

// File: rtl/muldiv_iter.sv
// Shared one-bit-per-cycle shift-add multiply / restoring divide datapath.
// Accumulator layout: {upper, lower} = {product hi, lo} or {remainder, quotient}.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             mode_mul,
  input  logic             step,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] nxt_hi_c,
  output logic [WIDTH-1:0] nxt_lo_c,
  output logic             last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  logic [ACC_W-1:0] acc_q, acc_step;
  logic [WIDTH-1:0] opnd_q;
  logic             mul_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   add_a, add_b;
  logic [WIDTH+1:0] sum;

  // One adder: add multiplicand for MUL, subtract divisor (carry = no borrow) for DIV.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (mul_q) begin
      add_a = {1'b0, acc_q[ACC_W-1:WIDTH]};
      add_b = acc_q[0] ? {1'b0, opnd_q} : '0;
    end else begin
      add_a = acc_q[ACC_W-1:WIDTH-1];
      add_b = ~{1'b0, opnd_q};
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(!mul_q);

    if (mul_q)
      acc_step = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
    else if (sum[WIDTH+1])
      acc_step = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_step = {acc_q[ACC_W-2:0], 1'b0};
  end

  assign acc_hi   = acc_q[ACC_W-1:WIDTH];
  assign acc_lo   = acc_q[WIDTH-1:0];
  assign nxt_hi_c = acc_step[ACC_W-1:WIDTH];
  assign nxt_lo_c = acc_step[WIDTH-1:0];
  assign last_c   = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mul_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      acc_q  <= {{WIDTH{1'b0}}, a_mag};
      opnd_q <= b_mag;
      mul_q  <= mode_mul;
      cnt_q  <= '0;
    end else if (step) begin
      acc_q  <= acc_step;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_control_mc.sv
// Multicycle ALU control: aluop/funct decode plus iterative mul/div sequencer with HI/LO.
// Define SIGNED_MULDIV_EN to also decode MULT/DIV as two's-complement operations.
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 3
) (
  input logic             clk,
  input logic             reset_n,
  alu_control_mc_if.slave bus
);

  localparam int unsigned ACC_W = 2 * WIDTH;

  state_t             state_q, state_d;
  logic               busy_q, done_q, sgn_q, mul_q, neg_q_q, neg_r_q;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic [CODE_W-1:0]  code;
  logic               dec_ill, is_multu, is_divu, is_mfhi, is_mflo, is_mult, is_div;
  logic               req_mul, req_div, req_signed, b_zero, load, step;
  logic [WIDTH-1:0]   a_mag, b_mag, acc_hi, acc_lo, nxt_hi, nxt_lo;
  logic               last;
  logic [ACC_W-1:0]   prod;

  // Instruction decode
  always_comb begin
    code     = ALU_AND;
    dec_ill  = 1'b0;
    is_multu = 1'b0;
    is_divu  = 1'b0;
    is_mfhi  = 1'b0;
    is_mflo  = 1'b0;
    is_mult  = 1'b0;
    is_div   = 1'b0;
    case (bus.aluop)
      AOP_ADD: code = ALU_ADD;
      AOP_SUB: code = ALU_SUB;
      AOP_RTYPE: begin
        case (bus.funct)
          F_ADD:   code = ALU_ADD;
          F_SUB:   code = ALU_SUB;
          F_AND:   code = ALU_AND;
          F_OR:    code = ALU_OR;
          F_SLT:   code = ALU_SLT;
          F_MULTU: is_multu = 1'b1;
          F_DIVU:  is_divu  = 1'b1;
          F_MFHI:  is_mfhi  = 1'b1;
          F_MFLO:  is_mflo  = 1'b1;
`ifdef SIGNED_MULDIV_EN
          F_MULT:  is_mult  = 1'b1;
          F_DIV:   is_div   = 1'b1;
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign req_mul    = bus.valid_in & (is_multu | is_mult);
  assign req_div    = bus.valid_in & (is_divu | is_div);
  assign req_signed = is_mult | is_div;
  assign b_zero     = (bus.b == '0);
  assign a_mag      = (req_signed & bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag      = (req_signed & bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
  assign prod       = {acc_hi, acc_lo};

  assign bus.alucontrol = CTRL_W'(code);
  assign bus.illegal    = dec_ill & bus.valid_in;
  assign bus.stall      = busy_q & bus.valid_in &
                          (is_multu | is_divu | is_mult | is_div | is_mfhi | is_mflo);
  assign bus.mf_data    = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .mode_mul (req_mul),
    .step     (step),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .nxt_hi_c (nxt_hi),
    .nxt_lo_c (nxt_lo),
    .last_c   (last)
  );

  // Sequencer next state; HI/LO only change on entry to FIN
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (req_mul) begin
          state_d = MUL;
          load    = 1'b1;
        end else if (req_div) begin
          if (b_zero) begin
            state_d = FIN;
            hi_d    = bus.a;
            lo_d    = '1;
          end else begin
            state_d = DIV;
            load    = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        step = 1'b1;
        if (last) begin
          if (sgn_q) begin
            state_d = SFIX;
          end else begin
            state_d = FIN;
            hi_d    = nxt_hi;
            lo_d    = nxt_lo;
          end
        end
      end
      SFIX: begin
        state_d = FIN;
        if (mul_q) begin
          {hi_d, lo_d} = neg_q_q ? (~prod + ACC_W'(1)) : prod;
        end else begin
          lo_d = neg_q_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
          hi_d = neg_r_q ? (~acc_hi + WIDTH'(1)) : acc_hi;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      mul_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == MUL) || (state_d == DIV) || (state_d == SFIX);
      done_q  <= (state_d == FIN);
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (load) begin
        sgn_q   <= req_signed;
        mul_q   <= req_mul;
        neg_q_q <= req_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r_q <= req_signed & bus.a[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Bench for alu_control_mc: decode sweep, vector table, random mul/div vs. arithmetic model,
// plus stall, busy-rejection, back-to-back and mid-operation reset sequences.
module tb_alu_control_mc;

  localparam int unsigned W = 32;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           bcnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_control_mc_if #(.WIDTH(W), .CTRL_W(3)) bus ();
  alu_control_mc #(.WIDTH(W), .CTRL_W(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] dec_tab [$];
  vec_t vt [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_dec(input logic [1:0] op, input logic [5:0] f, input logic v);
    logic [2:0] c;
    logic il;
    c = 3'b000;
    il = v;
    if (op == 2'b00) begin c = 3'b010; il = 1'b0; end
    else if (op == 2'b01) begin c = 3'b110; il = 1'b0; end
    else if (op == 2'b10) begin
      foreach (dec_tab[i]) if (dec_tab[i][8:3] == f) begin c = dec_tab[i][2:0]; il = 1'b0; end
    end
    return {c, il};
  endfunction

  function automatic vec_t mk(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] hi, input logic [W-1:0] lo, input int lat, input int bcnt);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.lat = lat; v.bcnt = bcnt;
    return v;
  endfunction

  task automatic start_op(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.valid_in = 1'b1;
    bus.aluop    = 2'b10;
    bus.funct    = f;
    bus.a        = av;
    bus.b        = bv;
    tick();
    bus.valid_in = 1'b0;
    bus.funct    = FN_ADD;
  endtask

  // Waits from cycle k0 (already at posedge+1) for done; lat = -1 on timeout.
  task automatic wait_done(input int k0, output int lat);
    lat = -1;
    for (int k = k0; k <= k0 + 100; k++) begin
      if (bus.done) begin lat = k; break; end
      tick();
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output int bcnt, output logic [W-1:0] rhi,
                        output logic [W-1:0] rlo, output bit held);
    logic [W-1:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    start_op(f, av, bv);
    lat = -1; bcnt = 0; held = 1'b1; rhi = '0; rlo = '0;
    for (int k = 1; k <= 100; k++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin lat = k; rhi = bus.hi; rlo = bus.lo; break; end
      if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bcnt, stall_cnt, dcnt;
    bit held, got;
    logic [W-1:0] rhi, rlo, ra, rb, exh, exl;
    logic [2*W-1:0] p;
    int exlat;
    bit isdiv;

    dec_tab = '{9'b100000_010, 9'b100010_110, 9'b100100_000, 9'b100101_001, 9'b101010_111,
                9'b011001_000, 9'b011011_000, 9'b010000_000, 9'b010010_000};
`ifdef SIGNED_MULDIV_EN
    dec_tab.push_back(9'b011000_000);
    dec_tab.push_back(9'b011010_000);
`endif
    bus.valid_in = 1'b0; bus.aluop = 2'b00; bus.funct = FN_ADD; bus.a = '0; bus.b = '0;

    // Decode sweep while held in reset so no operation can start
    for (int op = 0; op < 4; op++)
      for (int f = 0; f < 64; f++)
        for (int v = 0; v < 2; v++) begin
          bus.aluop = 2'(op); bus.funct = 6'(f); bus.valid_in = 1'(v);
          #1;
          check($sformatf("decode_op%0d_f%02h_v%0d", op, f, v),
                64'({bus.alucontrol, bus.illegal}), 64'(ref_dec(2'(op), 6'(f), 1'(v))));
        end

    bus.valid_in = 1'b1; bus.aluop = 2'b10; bus.funct = FN_MFHI;
    tick();
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_mf_data", 64'(bus.mf_data), 64'd0);
    bus.valid_in = 1'b0; bus.funct = FN_ADD;
    reset_n = 1'b1;
    tick();

    vt.push_back(mk(FN_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 33, 32));
    vt.push_back(mk(FN_MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 33, 32));
    vt.push_back(mk(FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 32));
    vt.push_back(mk(FN_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 0));
    vt.push_back(mk(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33, 32));
    vt.push_back(mk(FN_DIVU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 33, 32));
    vt.push_back(mk(FN_DIVU, 32'd3, 32'd10, 32'd3, 32'd0, 33, 32));
    vt.push_back(mk(FN_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, 32));
    vt.push_back(mk(FN_MULTU, 32'd0, 32'd12345, 32'd0, 32'd0, 33, 32));
    vt.push_back(mk(FN_MULTU, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 33, 32));

    foreach (vt[i]) begin
      run_op(vt[i].f, vt[i].a, vt[i].b, lat, bcnt, rhi, rlo, held);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(vt[i].bcnt));
      check($sformatf("vec%0d_hi", i), 64'(rhi), 64'(vt[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(rlo), 64'(vt[i].lo));
      check($sformatf("vec%0d_hold", i), 64'(held), 64'd1);
      tick();
      check($sformatf("vec%0d_done_one_cycle", i), 64'(bus.done), 64'd0);
    end

    // MFHI/MFLO readout of the last vector's result
    bus.valid_in = 1'b1; bus.aluop = 2'b10; bus.funct = FN_MFHI; #1;
    check("mfhi_data", 64'(bus.mf_data), 64'h1);
    bus.funct = FN_MFLO; #1;
    check("mflo_data", 64'(bus.mf_data), 64'h23456780);
    bus.funct = FN_ADD; #1;
    check("mf_data_other", 64'(bus.mf_data), 64'd0);
    bus.valid_in = 1'b0;
    tick();

    // Random MULTU/DIVU against plain arithmetic
    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      isdiv = 1'($urandom_range(0, 1));
      if (!isdiv) begin
        p = 64'(ra) * 64'(rb); exh = p[63:32]; exl = p[31:0]; exlat = 33;
      end else if (rb == 0) begin
        exh = ra; exl = '1; exlat = 1;
      end else begin
        exh = ra % rb; exl = ra / rb; exlat = 33;
      end
      run_op(isdiv ? FN_DIVU : FN_MULTU, ra, rb, lat, bcnt, rhi, rlo, held);
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exlat));
      check($sformatf("rnd%0d_hi", i), 64'(rhi), 64'(exh));
      check($sformatf("rnd%0d_lo", i), 64'(rlo), 64'(exl));
      tick();
    end

    // MFLO presented at cycle +5 of a MULTU stalls until FIN
    p = 64'(32'd123456) * 64'(32'd789);
    start_op(FN_MULTU, 32'd123456, 32'd789);
    repeat (4) tick();
    bus.valid_in = 1'b1; bus.aluop = 2'b10; bus.funct = FN_MFLO; #1;
    stall_cnt = 0; got = 1'b0;
    for (int k = 5; k <= 100; k++) begin
      if (bus.done) begin
        check("mflo_fin_stall", 64'(bus.stall), 64'd0);
        check("mflo_fin_data", 64'(bus.mf_data), 64'(p[31:0]));
        got = 1'b1;
        break;
      end
      if (bus.stall) stall_cnt++;
      tick();
    end
    check("mflo_reached_fin", 64'(got), 64'd1);
    check("mflo_stall_cycles", 64'(stall_cnt), 64'd28);
    bus.valid_in = 1'b0;
    tick();

    // Second MULTU during busy is rejected; plain ALU op is never stalled
    start_op(FN_MULTU, 32'd3, 32'd5);
    tick();
    bus.valid_in = 1'b1; bus.funct = FN_MULTU; bus.a = 32'd9; bus.b = 32'd9; #1;
    check("busy_multu_stall", 64'(bus.stall), 64'd1);
    tick();
    bus.funct = FN_ADD; #1;
    check("busy_add_no_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.valid_in = 1'b0;
    wait_done(4, lat);
    check("busy_reject_latency", 64'(lat), 64'd33);
    check("busy_reject_lo", 64'(bus.lo), 64'd15);
    check("busy_reject_hi", 64'(bus.hi), 64'd0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin tick(); if (bus.done || bus.busy) dcnt++; end
    check("busy_reject_no_second_op", 64'(dcnt), 64'd0);

    // Back-to-back: DIVU presented in the FIN cycle of a MULTU
    start_op(FN_MULTU, 32'd11, 32'd13);
    wait_done(1, lat);
    check("b2b_first_lo", 64'(bus.lo), 64'd143);
    start_op(FN_DIVU, 32'd1000, 32'd7);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(1, lat);
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_lo", 64'(bus.lo), 64'd142);
    check("b2b_hi", 64'(bus.hi), 64'd6);
    tick();

    // Reset at cycle +10 of a DIVU abandons it
    start_op(FN_DIVU, 32'd1000, 32'd3);
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_done", 64'(bus.done), 64'd0);
    check("rst_mid_hi", 64'(bus.hi), 64'd0);
    check("rst_mid_lo", 64'(bus.lo), 64'd0);
    reset_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin tick(); if (bus.done) dcnt++; end
    check("rst_mid_no_done", 64'(dcnt), 64'd0);
    run_op(FN_DIVU, 32'd100, 32'd7, lat, bcnt, rhi, rlo, held);
    check("post_rst_latency", 64'(lat), 64'd33);
    check("post_rst_lo", 64'(rlo), 64'd14);
    check("post_rst_hi", 64'(rhi), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
